scan_sync_tx: RTL



---
 rtl/scan_sync_tx_if.sv | 25 ++
 rtl/scan_sync_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/scan_sync_tx_if.sv
// Event inputs, status outputs and the serial sync-word link of scan_sync_tx.
// The slave modport is the transmitter's view; the master modport is the event source's view.
interface scan_sync_tx_if #(
  parameter int SERIAL_MODE = 1
);
  logic                   encode_zero_i;
  logic                   scan_begin_i;
  logic                   scan_test_i;
  logic                   scan_end_i;
  logic                   tx_busy_o;
  logic                   overflow_o;
  logic [7:0]             drop_cnt_o;
  logic                   SPI_MCLK;
  logic [SERIAL_MODE-1:0] SPI_MOSI;

  modport master (
    output encode_zero_i, scan_begin_i, scan_test_i, scan_end_i,
    input  tx_busy_o, overflow_o, drop_cnt_o, SPI_MCLK, SPI_MOSI
  );

  modport slave (
    input  encode_zero_i, scan_begin_i, scan_test_i, scan_end_i,
    output tx_busy_o, overflow_o, drop_cnt_o, SPI_MCLK, SPI_MOSI
  );
endinterface

// File: rtl/scan_sync_tx.sv
// Sync-word transmitter: encoder-zero events through a single pending flag, scan
// commands through a small FIFO, words shifted MSB-first on a source-synchronous link.
module scan_sync_tx #(
  parameter int DATA_WIDTH     = 16,
  parameter int SERIAL_MODE    = 1,
  parameter int CLK_DIV        = 4,
  parameter int GAP_BITS       = 4,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  scan_sync_tx_if.slave bus
);
  localparam int N    = DATA_WIDTH / SERIAL_MODE;
  localparam int AW   = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int PW   = $clog2(2 * CLK_DIV);
  localparam int MAXB = (N > GAP_BITS) ? N : GAP_BITS;
  localparam int BW   = $clog2(MAXB + 1);

  localparam logic [DATA_WIDTH-1:0] W_ENC   = DATA_WIDTH'(16'hECDE);
  localparam logic [DATA_WIDTH-1:0] W_BEGIN = DATA_WIDTH'(16'h5A51);
  localparam logic [DATA_WIDTH-1:0] W_TEST  = DATA_WIDTH'(16'h5A53);
  localparam logic [DATA_WIDTH-1:0] W_END   = DATA_WIDTH'(16'h5A50);

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t                  state_q;
  logic [PW-1:0]           phase_q;
  logic [BW-1:0]           beat_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    mclk_q;
  logic [SERIAL_MODE-1:0]  mosi_q;

  logic                    enc_pend_q, enc_pend_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem_q [CMD_FIFO_DEPTH];

  logic                    cmd_valid, fifo_full, push, pop, load_enc, load;
  logic                    drop_enc, drop_full, last_phase;
  logic [1:0]              n_cmd, cmd_lost;
  logic [2:0]              drops;
  logic [8:0]              drop_sum;
  logic [DATA_WIDTH-1:0]   cmd_word, load_word;
  logic [PW-1:0]           phase_nxt;

  always_comb begin
    cmd_valid = bus.scan_end_i | bus.scan_test_i | bus.scan_begin_i;
    cmd_word  = bus.scan_end_i ? W_END : (bus.scan_test_i ? W_TEST : W_BEGIN);
    n_cmd     = 2'(bus.scan_begin_i) + 2'(bus.scan_test_i) + 2'(bus.scan_end_i);
    cmd_lost  = cmd_valid ? (n_cmd - 2'd1) : 2'd0;
    fifo_full = (cnt_q == (AW+1)'(CMD_FIFO_DEPTH));

    // The pending encode word always beats the FIFO when the line is free.
    load_enc  = (state_q == IDLE) && enc_pend_q;
    pop       = (state_q == IDLE) && !enc_pend_q && (cnt_q != '0);
    load      = load_enc | pop;
    load_word = load_enc ? W_ENC : mem_q[rd_ptr_q];

    push      = cmd_valid && !fifo_full;
    drop_full = cmd_valid && fifo_full;
    drop_enc  = bus.encode_zero_i && enc_pend_q && !load_enc;
    drops     = 3'(drop_enc) + 3'(cmd_lost) + 3'(drop_full);
    drop_sum  = {1'b0, drop_cnt_q} + 9'(drops);

    enc_pend_d = bus.encode_zero_i ? 1'b1 : (load_enc ? 1'b0 : enc_pend_q);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_d = (drops != 3'd0);
    busy_d     = (state_q != IDLE) || enc_pend_q || (cnt_q != '0);

    phase_nxt  = phase_q + PW'(1);
    last_phase = (phase_q == PW'(2 * CLK_DIV - 1));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enc_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      enc_pend_q <= enc_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cmd_word;
  end

  // Every period starts low; MOSI only moves on the period boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      beat_q  <= '0;
      shift_q <= '0;
      mclk_q  <= 1'b0;
      mosi_q  <= '0;
    end else if (state_q == IDLE) begin
      if (load) begin
        state_q <= START;
        phase_q <= '0;
        beat_q  <= '0;
        shift_q <= load_word;
        mclk_q  <= 1'b0;
        mosi_q  <= '1;
      end
    end else if (!last_phase) begin
      phase_q <= phase_nxt;
      mclk_q  <= (state_q != GAP) && (phase_nxt >= PW'(CLK_DIV));
    end else begin
      phase_q <= '0;
      mclk_q  <= 1'b0;
      case (state_q)
        START: begin
          state_q <= SHIFT;
          beat_q  <= '0;
          mosi_q  <= shift_q[DATA_WIDTH-1 -: SERIAL_MODE];
          shift_q <= shift_q << SERIAL_MODE;
        end
        SHIFT: begin
          if (beat_q == BW'(N - 1)) begin
            state_q <= GAP;
            beat_q  <= '0;
            mosi_q  <= '0;
          end else begin
            beat_q  <= beat_q + BW'(1);
            mosi_q  <= shift_q[DATA_WIDTH-1 -: SERIAL_MODE];
            shift_q <= shift_q << SERIAL_MODE;
          end
        end
        GAP: begin
          if (beat_q == BW'(GAP_BITS - 1)) begin
            state_q <= IDLE;
            beat_q  <= '0;
          end else begin
            beat_q  <= beat_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SPI_MCLK   = mclk_q;
  assign bus.SPI_MOSI   = mosi_q;
  assign bus.tx_busy_o  = busy_q;
  assign bus.overflow_o = overflow_q;
  assign bus.drop_cnt_o = drop_cnt_q;
endmodule
